// File: rtl/pt100_sample_ctrl.sv
// -----------------------------------------------------------------------------
// pt100_sample_ctrl
//
// Purpose:
//   Paces periodic PT100 measurements. Every PERIOD_CYCLES clocks a burst of
//   2^AVG_LOG2 ADC conversions is requested one at a time. Each result is
//   accumulated, and the average is scaled to degrees C as avg*140/1024
//   (0..139 C). The result is presented on temp_o with a one-cycle
//   temp_valid_o pulse.
//
// Ports:
//   clk_i         in   1        system clock, rising edge
//   rst_n_i       in   1        asynchronous active-low reset
//   enable_i      in   1        1 = run periodic measurements, 0 = abort to IDLE
//   adc_start_o   out  1        one-cycle conversion request
//   adc_done_i    in   1        one-cycle conversion-complete pulse
//   adc_data_i    in   ADC_RES  conversion result, valid with adc_done_i
//   temp_o        out  8        last averaged temperature (C)
//   temp_valid_o  out  1        one-cycle pulse when temp_o updates
//   busy_o        out  1        burst in progress (START/WAIT_DONE/CONVERT)
//   err_o         out  1        sticky ADC timeout flag, cleared by enable_i=0
//   overtemp_o    out  1        over-temperature alarm
//
// Build option:
//   OVERTEMP_HYST_EN  when defined, overtemp_o sets when a new temperature is
//                     >= ALARM_HI and clears when a new temperature is
//                     <= ALARM_LO. Otherwise overtemp_o = (temp_o >= ALARM_HI).
// -----------------------------------------------------------------------------
module pt100_sample_ctrl #(
    parameter int unsigned ADC_RES        = 10,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned PERIOD_CYCLES  = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ALARM_HI       = 100,
    parameter int unsigned ALARM_LO       = 95
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
    output logic               adc_start_o,
    input  logic               adc_done_i,
    input  logic [ADC_RES-1:0] adc_data_i,
    output logic [7:0]         temp_o,
    output logic               temp_valid_o,
    output logic               busy_o,
    output logic               err_o,
    output logic               overtemp_o
);

    localparam int unsigned PER_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SCNT_W = AVG_LOG2 + 1;
    localparam int unsigned ACC_W  = ADC_RES + AVG_LOG2;
    localparam int unsigned PROD_W = ADC_RES + 8;

    // Elaboration-time parameter sanity checks.
    if (AVG_LOG2 > 4) begin : g_bad_avg
        $error("pt100_sample_ctrl: AVG_LOG2 must be 0..4");
    end
    if (PERIOD_CYCLES < 2) begin : g_bad_period
        $error("pt100_sample_ctrl: PERIOD_CYCLES must be >= 2");
    end
    if (ALARM_LO > ALARM_HI) begin : g_bad_alarm
        $error("pt100_sample_ctrl: ALARM_LO must be <= ALARM_HI");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CONVERT   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PER_W-1:0]    period_q, period_d;
    logic [TO_W-1:0]     tmo_q, tmo_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [7:0]          temp_q, temp_d;
    logic                err_q, err_d;
`ifdef OVERTEMP_HYST_EN
    logic                ot_q, ot_d;
`endif

    logic                tick;
    logic [ACC_W-1:0]    sum;
    logic [ADC_RES-1:0]  avg;
    logic [PROD_W-1:0]   prod;
    logic [7:0]          new_temp;

    // Datapath for the sample that completes a burst: the scaled value is
    // registered on the same edge that enters CONVERT, so temp_o and
    // temp_valid_o appear together one cycle after the last adc_done_i.
    always_comb begin
        sum      = acc_q + ACC_W'(adc_data_i);
        avg      = ADC_RES'(sum >> AVG_LOG2);
        prod     = PROD_W'(avg) * PROD_W'(140);
        new_temp = 8'(prod >> ADC_RES);
    end

    assign tick = (period_q == PER_W'(PERIOD_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        // The period counter free-runs outside IDLE so burst starts stay
        // exactly PERIOD_CYCLES apart; ticks seen while busy are dropped.
        period_d = tick ? '0 : period_q + PER_W'(1);
        tmo_d    = tmo_q;
        scnt_d   = scnt_q;
        acc_d    = acc_q;
        temp_d   = temp_q;
        err_d    = err_q;
`ifdef OVERTEMP_HYST_EN
        ot_d     = ot_q;
`endif

        if (!enable_i) begin
            // Abort from any state; temp_o (and the alarm) are held.
            state_d  = ST_IDLE;
            period_d = '0;
            tmo_d    = '0;
            scnt_d   = '0;
            acc_d    = '0;
            err_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    period_d = '0;
                    state_d  = ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (tick) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (adc_done_i) begin
                        if (scnt_q == SCNT_W'((1 << AVG_LOG2) - 1)) begin
                            scnt_d  = '0;
                            acc_d   = '0;
                            temp_d  = new_temp;
`ifdef OVERTEMP_HYST_EN
                            if (new_temp >= 8'(ALARM_HI)) begin
                                ot_d = 1'b1;
                            end else if (new_temp <= 8'(ALARM_LO)) begin
                                ot_d = 1'b0;
                            end
`endif
                            state_d = ST_CONVERT;
                        end else begin
                            scnt_d  = scnt_q + SCNT_W'(1);
                            acc_d   = sum;
                            state_d = ST_START;
                        end
                    end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // ADC never answered: drop the partial burst.
                        err_d   = 1'b1;
                        scnt_d  = '0;
                        acc_d   = '0;
                        state_d = ST_WAIT_TICK;
                    end else begin
                        tmo_d = tmo_q + TO_W'(1);
                    end
                end
                ST_CONVERT: begin
                    state_d = ST_WAIT_TICK;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            tmo_q    <= '0;
            scnt_q   <= '0;
            acc_q    <= '0;
            temp_q   <= '0;
            err_q    <= 1'b0;
`ifdef OVERTEMP_HYST_EN
            ot_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            tmo_q    <= tmo_d;
            scnt_q   <= scnt_d;
            acc_q    <= acc_d;
            temp_q   <= temp_d;
            err_q    <= err_d;
`ifdef OVERTEMP_HYST_EN
            ot_q     <= ot_d;
`endif
        end
    end

    assign adc_start_o  = (state_q == ST_START);
    assign temp_valid_o = (state_q == ST_CONVERT);
    assign busy_o       = (state_q == ST_START) || (state_q == ST_WAIT_DONE) ||
                          (state_q == ST_CONVERT);
    assign temp_o       = temp_q;
    assign err_o        = err_q;
`ifdef OVERTEMP_HYST_EN
    assign overtemp_o   = ot_q;
`else
    assign overtemp_o   = (temp_q >= 8'(ALARM_HI));
`endif

endmodule

// File: tb/tb_pt100_sample_ctrl.sv
module tb_pt100_sample_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       adc_start;
    logic       adc_done;
    logic [9:0] adc_data;
    logic [7:0] temp;
    logic       temp_valid;
    logic       busy;
    logic       err;
    logic       overtemp;

    always #5 clk = ~clk;

    pt100_sample_ctrl #(
        .ADC_RES       (10),
        .AVG_LOG2      (2),
        .PERIOD_CYCLES (20),
        .TIMEOUT_CYCLES(16),
        .ALARM_HI      (100),
        .ALARM_LO      (95)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .enable_i    (enable),
        .adc_start_o (adc_start),
        .adc_done_i  (adc_done),
        .adc_data_i  (adc_data),
        .temp_o      (temp),
        .temp_valid_o(temp_valid),
        .busy_o      (busy),
        .err_o       (err),
        .overtemp_o  (overtemp)
    );

    int checks   = 0;
    int failures = 0;

    // Monitor: cycle count, temp_valid pulses, adc_start timestamps.
    int cyc       = 0;
    int valid_cnt = 0;
    int start_n   = 0;
    int st [0:15];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (temp_valid === 1'b1) valid_cnt++;
            if (adc_start === 1'b1) begin
                if (start_n < 16) st[start_n] = cyc;
                start_n++;
            end
        end
    end

    // ADC model: answers each adc_start pulse 3 cycles later with the next
    // entry of samp[] (rotating), unless muted.
    logic [9:0] samp [0:3];
    int  samp_idx = 0;
    int  pend     = 0;
    bit  mute     = 1'b0;
    int  done_cnt = 0;

    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    adc_done = 1'b1;
                    adc_data = samp[samp_idx];
                    samp_idx = (samp_idx + 1) % 4;
                    done_cnt++;
                end
            end
            if (adc_start === 1'b1 && !mute) pend = 2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_samp(input int s0, input int s1, input int s2, input int s3);
        samp[0] = 10'(s0);
        samp[1] = 10'(s1);
        samp[2] = 10'(s2);
        samp[3] = 10'(s3);
    endtask

    // Wait (bounded) for a temp_valid pulse, then check the result cycle and
    // the cycle after it.
    task automatic burst(input string tag, input int exp_temp, input int exp_ot);
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (temp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_valid_seen"}, 32'(seen), 1);
        check({tag, "_temp"}, 32'(temp), 32'(exp_temp));
        check({tag, "_busy_in_convert"}, 32'(busy), 1);
        check({tag, "_overtemp"}, 32'(overtemp), 32'(exp_ot));
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, 32'(temp_valid), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    int  vc;
    int  base;
    int  s0;
    bit  got;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        set_samp(0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_adc_start", 32'(adc_start), 0);
        check("rst_temp", 32'(temp), 0);
        check("rst_temp_valid", 32'(temp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_overtemp", 32'(overtemp), 0);

        rst_n = 1'b1;
        @(negedge clk);

        // Average of 100,200,300,400 = 250 -> 250*140/1024 = 34
        set_samp(100, 200, 300, 400);
        enable = 1'b1;
        burst("avg4", 34, 0);
        burst("avg4_b2", 34, 0);
        check("start_spacing_in_burst", 32'(st[1] - st[0]), 3);
        check("burst_period", 32'(st[4] - st[0]), 20);
        check("start_count_two_bursts", 32'(start_n), 8);

        // Scaling end points: 1023 -> 139, 512 -> 70, 0 -> 0
        set_samp(1023, 1023, 1023, 1023);
        burst("scale_1023", 139, 1);
        set_samp(512, 512, 512, 512);
        burst("scale_512", 70, 0);
        set_samp(0, 0, 0, 0);
        burst("scale_0", 0, 0);

        // Alarm: 739 -> 101 C, 710 -> 97 C, 688 -> 94 C
        set_samp(739, 739, 739, 739);
        burst("ot_101", 101, 1);
        set_samp(710, 710, 710, 710);
`ifdef OVERTEMP_HYST_EN
        burst("ot_97", 97, 1);
`else
        burst("ot_97", 97, 0);
`endif
        set_samp(688, 688, 688, 688);
        burst("ot_94", 94, 0);

        // Timeout: ADC silent
        mute = 1'b1;
        vc   = valid_cnt;
        got  = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("tmo_err_set", 32'(got), 1);
        check("tmo_temp_held", 32'(temp), 94);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_no_valid", 32'(valid_cnt), 32'(vc));

        // Bursts continue while err is set
        set_samp(100, 200, 300, 400);
        mute = 1'b0;
        burst("after_err", 34, 0);
        check("err_sticky", 32'(err), 1);

        // enable low clears err
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("dis_err_clr", 32'(err), 0);
        check("dis_busy", 32'(busy), 0);
        check("dis_temp_held", 32'(temp), 34);
        enable = 1'b1;

        // Abort after 2 of 4 samples, then a fresh burst of zeros must read 0
        set_samp(1023, 1023, 1023, 1023);
        base = done_cnt;
        got  = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done_cnt >= base + 2) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_two_samples", 32'(got), 1);
        @(negedge clk);
        enable = 1'b0;
        vc     = valid_cnt;
        repeat (3) @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_temp_held", 32'(temp), 34);
        set_samp(0, 0, 0, 0);
        repeat (5) @(negedge clk);
        check("abort_no_valid", 32'(valid_cnt), 32'(vc));
        enable = 1'b1;
        burst("fresh_after_abort", 0, 0);

        // Asynchronous reset mid-burst
        set_samp(512, 512, 512, 512);
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("mid_start_seen", 32'(got), 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_temp", 32'(temp), 0);
        check("arst_adc_start", 32'(adc_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_n;
        repeat (19) @(negedge clk);
        check("arst_no_early_start", 32'(start_n), 32'(s0));
        burst("after_arst", 70, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
